// File: rtl/frame_validator_if.sv
// -----------------------------------------------------------------------------
// frame_validator_if
// Bundle between the UART framing interface (master) and frame_validator
// (slave).
//
// Signals:
//   fin          master->slave  de-escaped frame, byte k = fin[k*8+:8]
//   fin_valid    master->slave  frame-present strobe
//   confirm      slave->master  one-cycle confirm pulse
//   conf_code    slave->master  8'h05 OKAY / 8'h04 ERROR
//   err_cause    slave->master  0 none, 1 CRC, 2 bad type, 3 sequence
//   pout         slave->master  nonce||data of the last accepted frame
//   pout_valid   slave->master  one-cycle pulse on accept
//   pout_type    slave->master  type byte of the last accepted frame
//   busy         slave->master  frame capture up to and including confirm
//   session_open slave->master  multi-frame session in progress
// -----------------------------------------------------------------------------
interface frame_validator_if #(
  parameter int PREAMBLE_SIZE = 7,
  parameter int NONCE_SIZE    = 8,
  parameter int DATA_SIZE     = 16,
  parameter int CRC_SIZE      = 2
);
  localparam int FRAME_SIZE   = PREAMBLE_SIZE + NONCE_SIZE + DATA_SIZE + CRC_SIZE;
  localparam int PAYLOAD_SIZE = NONCE_SIZE + DATA_SIZE;

  logic [0:FRAME_SIZE*8-1]   fin;
  logic                      fin_valid;
  logic                      confirm;
  logic [7:0]                conf_code;
  logic [1:0]                err_cause;
  logic [0:PAYLOAD_SIZE*8-1] pout;
  logic                      pout_valid;
  logic [7:0]                pout_type;
  logic                      busy;
  logic                      session_open;

  modport master (
    output fin, fin_valid,
    input  confirm, conf_code, err_cause, pout, pout_valid, pout_type,
           busy, session_open
  );

  modport slave (
    input  fin, fin_valid,
    output confirm, conf_code, err_cause, pout, pout_valid, pout_type,
           busy, session_open
  );
endinterface

// File: rtl/frame_validator.sv
// -----------------------------------------------------------------------------
// frame_validator
// Checks each de-escaped frame from the UART framing interface: CRC-16/CCITT-
// FALSE over everything but the CRC tail, the frame type, and (optionally) the
// frame sequence number. Answers with a one-cycle confirm + conf_code and
// forwards the nonce||data payload of accepted frames to the crypto core.
//
// Frame layout (bytes): [0] type, [1:2] reserved, [3:6] frame number (BE),
//   then NONCE_SIZE nonce bytes, DATA_SIZE data bytes, CRC_SIZE (=2) CRC (BE).
//
// Ports:
//   clk  rising-edge system clock
//   rst  asynchronous active-high reset
//   bus  frame_validator_if.slave (fin/fin_valid in; confirm, conf_code,
//        err_cause, pout, pout_valid, pout_type, busy, session_open out)
//
// Build option:
//   FRAME_VALIDATOR_SEQ_CHECK_EN  when defined, the frame number is tracked
//   against expected_nr and session rules yield err_cause=3. When undefined,
//   no number tracking exists; FIRST/LAST still open/close the session.
// -----------------------------------------------------------------------------
module frame_validator #(
  parameter int PREAMBLE_SIZE = 7,
  parameter int NONCE_SIZE    = 8,
  parameter int DATA_SIZE     = 16,
  parameter int CRC_SIZE      = 2
) (
  input logic               clk,
  input logic               rst,
  frame_validator_if.slave  bus
);

  localparam int FRAME_SIZE   = PREAMBLE_SIZE + NONCE_SIZE + DATA_SIZE + CRC_SIZE;
  localparam int CRC_BYTES    = FRAME_SIZE - CRC_SIZE;
  localparam int PAYLOAD_BITS = (NONCE_SIZE + DATA_SIZE) * 8;
  localparam int IDX_W        = $clog2(FRAME_SIZE + 1);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CRC_BYTES - 1);

  localparam logic [7:0] TYPE_FIRST  = 8'h00;
  localparam logic [7:0] TYPE_LAST   = 8'h01;
  localparam logic [7:0] TYPE_NORMAL = 8'h02;
  localparam logic [7:0] TYPE_SINGLE = 8'h03;
  localparam logic [7:0] CODE_OKAY   = 8'h05;
  localparam logic [7:0] CODE_ERROR  = 8'h04;

  localparam logic [1:0] CAUSE_NONE = 2'd0;
  localparam logic [1:0] CAUSE_CRC  = 2'd1;
  localparam logic [1:0] CAUSE_TYPE = 2'd2;
`ifdef FRAME_VALIDATOR_SEQ_CHECK_EN
  localparam logic [1:0] CAUSE_SEQ  = 2'd3;
`endif

  typedef enum logic [1:0] {IDLE, CRC, CHECK, REPLY} state_t;

  state_t                    r_state;
  logic [0:FRAME_SIZE*8-1]   r_frame;
  logic [15:0]               r_crc;
  logic [IDX_W-1:0]          r_idx;
  logic [1:0]                r_pendCause;
  logic                      r_confirm;
  logic [7:0]                r_confCode;
  logic [1:0]                r_errCause;
  logic [0:PAYLOAD_BITS-1]   r_pout;
  logic                      r_poutValid;
  logic [7:0]                r_poutType;
  logic                      r_busy;
  logic                      r_session;
`ifdef FRAME_VALIDATOR_SEQ_CHECK_EN
  logic [31:0]               r_expNr;
  logic [31:0]               w_nr;
  logic                      w_seqOk;
`endif

  logic [7:0]  w_curByte;
  logic [7:0]  w_type;
  logic [15:0] w_rxCrc;
  logic [1:0]  w_cause;

  // CRC-16/CCITT-FALSE, one byte, MSB first, no reflection.
  function automatic logic [15:0] crcByte(input logic [15:0] crcIn,
                                          input logic [7:0]  data);
    logic [15:0] c;
    c = crcIn ^ {data, 8'h00};
    for (int b = 0; b < 8; b++) begin
      c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c;
  endfunction

  // Byte fields of the latched frame. The frame vector is ascending, so
  // [k*8 +: 8] gives byte k with its MSB at the lowest bit index.
  always_comb begin
    w_curByte = r_frame[int'(r_idx)*8 +: 8];
    w_type    = r_frame[0 +: 8];
    w_rxCrc   = {r_frame[(FRAME_SIZE-2)*8 +: 8], r_frame[(FRAME_SIZE-1)*8 +: 8]};
  end

`ifdef FRAME_VALIDATOR_SEQ_CHECK_EN
  // Sequence rules: FIRST always allowed, NORMAL/LAST must continue an open
  // session with the expected number, SINGLE must not interrupt a session.
  always_comb begin
    w_nr    = r_frame[3*8 +: 32];
    w_seqOk = 1'b0;
    case (w_type)
      TYPE_FIRST:            w_seqOk = 1'b1;
      TYPE_NORMAL, TYPE_LAST: w_seqOk = r_session && (w_nr == r_expNr);
      TYPE_SINGLE:           w_seqOk = !r_session;
      default:               w_seqOk = 1'b0;
    endcase
  end
`endif

  // Error cause in priority order: CRC, then type, then sequence.
  always_comb begin
    w_cause = CAUSE_NONE;
    if (r_crc != w_rxCrc) begin
      w_cause = CAUSE_CRC;
    end else if (w_type > TYPE_SINGLE) begin
      w_cause = CAUSE_TYPE;
`ifdef FRAME_VALIDATOR_SEQ_CHECK_EN
    end else if (!w_seqOk) begin
      w_cause = CAUSE_SEQ;
`endif
    end
  end

  // Main FSM. All outputs are registered, so the confirm/pout_valid pulse
  // appears in the cycle after REPLY. busy is still high in that cycle and is
  // dropped from IDLE on the following edge; a fin_valid arriving during that
  // confirm cycle is ignored like any other fin_valid while busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_frame     <= '0;
      r_crc       <= 16'h0000;
      r_idx       <= '0;
      r_pendCause <= CAUSE_NONE;
      r_confirm   <= 1'b0;
      r_confCode  <= 8'h00;
      r_errCause  <= CAUSE_NONE;
      r_pout      <= '0;
      r_poutValid <= 1'b0;
      r_poutType  <= 8'h00;
      r_busy      <= 1'b0;
      r_session   <= 1'b0;
`ifdef FRAME_VALIDATOR_SEQ_CHECK_EN
      r_expNr     <= 32'h0;
`endif
    end else begin
      r_confirm   <= 1'b0;
      r_poutValid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (r_busy) begin
            r_busy <= 1'b0;
          end else if (bus.fin_valid) begin
            r_frame <= bus.fin;
            r_crc   <= 16'hFFFF;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= CRC;
          end
        end

        CRC: begin
          r_crc <= crcByte(r_crc, w_curByte);
          if (r_idx == LAST_IDX) begin
            r_state <= CHECK;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end

        CHECK: begin
          r_pendCause <= w_cause;
          r_state     <= REPLY;
        end

        REPLY: begin
          r_confirm  <= 1'b1;
          r_errCause <= r_pendCause;
          r_confCode <= (r_pendCause == CAUSE_NONE) ? CODE_OKAY : CODE_ERROR;
          if (r_pendCause == CAUSE_NONE) begin
            r_pout      <= r_frame[PREAMBLE_SIZE*8 +: PAYLOAD_BITS];
            r_poutType  <= w_type;
            r_poutValid <= 1'b1;
            // Session bookkeeping happens only for accepted frames.
            case (w_type)
              TYPE_FIRST: begin
                r_session <= 1'b1;
`ifdef FRAME_VALIDATOR_SEQ_CHECK_EN
                r_expNr   <= w_nr + 32'd1;
`endif
              end
              TYPE_LAST: begin
                r_session <= 1'b0;
`ifdef FRAME_VALIDATOR_SEQ_CHECK_EN
                r_expNr   <= 32'h0;
`endif
              end
`ifdef FRAME_VALIDATOR_SEQ_CHECK_EN
              TYPE_NORMAL: r_expNr <= r_expNr + 32'd1;
`endif
              default: ;
            endcase
          end
          r_state <= IDLE;
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.confirm      = r_confirm;
  assign bus.conf_code    = r_confCode;
  assign bus.err_cause    = r_errCause;
  assign bus.pout         = r_pout;
  assign bus.pout_valid   = r_poutValid;
  assign bus.pout_type    = r_poutType;
  assign bus.busy         = r_busy;
  assign bus.session_open = r_session;

endmodule

// File: tb/tb_frame_validator.sv
// -----------------------------------------------------------------------------
// tb_frame_validator
// Directed bench for frame_validator at default sizes (33-byte frames).
// Expected values for sequence errors follow FRAME_VALIDATOR_SEQ_CHECK_EN.
// -----------------------------------------------------------------------------
module tb_frame_validator;

  localparam int FRAME_SIZE = 33;
  localparam int N          = 31;
  localparam int FB         = FRAME_SIZE * 8;
  localparam int PB         = 24 * 8;
  localparam int LATENCY    = 33;

  localparam logic [7:0] T_FIRST  = 8'h00;
  localparam logic [7:0] T_LAST   = 8'h01;
  localparam logic [7:0] T_NORMAL = 8'h02;
  localparam logic [7:0] T_SINGLE = 8'h03;

`ifdef FRAME_VALIDATOR_SEQ_CHECK_EN
  localparam bit SEQ_ON = 1'b1;
`else
  localparam bit SEQ_ON = 1'b0;
`endif

  logic clk;
  logic rst;

  frame_validator_if bus ();

  frame_validator dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int nCompared   = 0;
  int nMismatched = 0;

  // Values captured in the confirm cycle of the last frame.
  logic            cGot;
  int              cEdges;
  logic [7:0]      cCode;
  logic [1:0]      cCause;
  logic            cPV;
  logic            cBusy;
  logic            cSess;
  logic [7:0]      cType;
  logic [0:PB-1]   cPout;

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Backstop in case something stalls outside the bounded waits.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Build a frame with a correct CRC tail.
  function automatic logic [0:FB-1] makeFrame(input logic [7:0]  t,
                                               input logic [31:0] nr,
                                               input logic [7:0]  seed);
    logic [0:FB-1] f;
    logic [15:0]   c;
    f          = '0;
    f[0 +: 8]  = t;
    f[8 +: 8]  = 8'hA5;
    f[16 +: 8] = 8'h5A;
    f[24 +: 32] = nr;
    for (int k = 7; k < N; k++) f[k*8 +: 8] = seed + 8'(k * 3);
    c = 16'hFFFF;
    for (int k = 0; k < N; k++) begin
      c = c ^ {f[k*8 +: 8], 8'h00};
      for (int b = 0; b < 8; b++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    f[N*8 +: 16] = c;
    return f;
  endfunction

  // Drive one fin_valid pulse.
  task automatic applyStimulus(input logic [0:FB-1] f);
    repeat (3) @(negedge clk);
    bus.fin       = f;
    bus.fin_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.fin_valid = 1'b0;
  endtask

  // Send a frame and wait (bounded) for its confirm, capturing outputs.
  task automatic sendFrame(input logic [0:FB-1] f);
    applyStimulus(f);
    cGot   = 1'b0;
    cEdges = 0;
    while (!cGot && cEdges < 60) begin
      @(posedge clk);
      #1;
      cEdges++;
      if (bus.confirm) begin
        cGot   = 1'b1;
        cCode  = bus.conf_code;
        cCause = bus.err_cause;
        cPV    = bus.pout_valid;
        cBusy  = bus.busy;
        cSess  = bus.session_open;
        cType  = bus.pout_type;
        cPout  = bus.pout;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.fin = '0;
    bus.fin_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    nCompared++; if (bus.confirm !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_confirm: got %b expected 0", bus.confirm); end
    nCompared++; if (bus.conf_code !== 8'h00) begin nMismatched++; $display("[TB] FAIL reset_code: got %h expected 00", bus.conf_code); end
    nCompared++; if (bus.err_cause !== 2'd0) begin nMismatched++; $display("[TB] FAIL reset_cause: got %0d expected 0", bus.err_cause); end
    nCompared++; if (bus.pout_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_pout_valid: got %b expected 0", bus.pout_valid); end
    nCompared++; if (bus.busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); end
    nCompared++; if (bus.session_open !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_session: got %b expected 0", bus.session_open); end
    nCompared++; if (bus.pout !== '0) begin nMismatched++; $display("[TB] FAIL reset_pout: got %h expected 0", bus.pout); end
    nCompared++; if (bus.pout_type !== 8'h00) begin nMismatched++; $display("[TB] FAIL reset_pout_type: got %h expected 00", bus.pout_type); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic [0:FB-1] f;
    f = makeFrame(T_SINGLE, 32'h0, 8'h11);
    sendFrame(f);
    nCompared++; if (cGot !== 1'b1) begin nMismatched++; $display("[TB] FAIL single_confirm: got %b expected 1", cGot); end
    nCompared++; if (cEdges !== LATENCY) begin nMismatched++; $display("[TB] FAIL single_latency: got %0d edges expected %0d", cEdges, LATENCY); end
    nCompared++; if (cCode !== 8'h05) begin nMismatched++; $display("[TB] FAIL single_code: got %h expected 05", cCode); end
    nCompared++; if (cCause !== 2'd0) begin nMismatched++; $display("[TB] FAIL single_cause: got %0d expected 0", cCause); end
    nCompared++; if (cPV !== 1'b1) begin nMismatched++; $display("[TB] FAIL single_pout_valid: got %b expected 1", cPV); end
    nCompared++; if (cPout !== f[56 +: PB]) begin nMismatched++; $display("[TB] FAIL single_pout: got %h expected %h", cPout, f[56 +: PB]); end
    nCompared++; if (cType !== T_SINGLE) begin nMismatched++; $display("[TB] FAIL single_type: got %h expected 03", cType); end
    nCompared++; if (cSess !== 1'b0) begin nMismatched++; $display("[TB] FAIL single_session: got %b expected 0", cSess); end
    nCompared++; if (cBusy !== 1'b1) begin nMismatched++; $display("[TB] FAIL single_busy_in_confirm: got %b expected 1", cBusy); end
    @(posedge clk);
    #1;
    nCompared++; if (bus.busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL single_busy_after: got %b expected 0", bus.busy); end
    nCompared++; if (bus.pout_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL single_pv_pulse: got %b expected 0", bus.pout_valid); end
  endtask

  task automatic test_crc_error();
    logic [0:FB-1] good;
    logic [0:FB-1] bad;
    good = makeFrame(T_SINGLE, 32'h0, 8'h11);
    bad  = good;
    bad[80 +: 8] = bad[80 +: 8] ^ 8'hFF;
    sendFrame(bad);
    nCompared++; if (cGot !== 1'b1) begin nMismatched++; $display("[TB] FAIL crc_confirm: got %b expected 1", cGot); end
    nCompared++; if (cCode !== 8'h04) begin nMismatched++; $display("[TB] FAIL crc_code: got %h expected 04", cCode); end
    nCompared++; if (cCause !== 2'd1) begin nMismatched++; $display("[TB] FAIL crc_cause: got %0d expected 1", cCause); end
    nCompared++; if (cPV !== 1'b0) begin nMismatched++; $display("[TB] FAIL crc_pout_valid: got %b expected 0", cPV); end
    nCompared++; if (cPout !== good[56 +: PB]) begin nMismatched++; $display("[TB] FAIL crc_pout_hold: got %h expected %h", cPout, good[56 +: PB]); end
  endtask

  task automatic test_sequence();
    logic [7:0]  types [5];
    logic [31:0] nrs   [5];
    logic [7:0]  eCode [5];
    logic [1:0]  eCause[5];
    types  = '{T_FIRST, T_NORMAL, T_NORMAL, T_NORMAL, T_LAST};
    nrs    = '{32'd5, 32'd6, 32'd8, 32'd7, 32'd8};
    eCode  = '{8'h05, 8'h05, (SEQ_ON ? 8'h04 : 8'h05), 8'h05, 8'h05};
    eCause = '{2'd0, 2'd0, (SEQ_ON ? 2'd3 : 2'd0), 2'd0, 2'd0};
    for (int i = 0; i < 5; i++) begin
      sendFrame(makeFrame(types[i], nrs[i], 8'(8'h20 + i)));
      nCompared++; if (cGot !== 1'b1) begin nMismatched++; $display("[TB] FAIL seq_confirm[%0d]: got %b expected 1", i, cGot); end
      nCompared++; if (cCode !== eCode[i]) begin nMismatched++; $display("[TB] FAIL seq_code[%0d]: got %h expected %h", i, cCode, eCode[i]); end
      nCompared++; if (cCause !== eCause[i]) begin nMismatched++; $display("[TB] FAIL seq_cause[%0d]: got %0d expected %0d", i, cCause, eCause[i]); end
      if (i == 0) begin
        nCompared++; if (cSess !== 1'b1) begin nMismatched++; $display("[TB] FAIL seq_session_open: got %b expected 1", cSess); end
      end
    end
    nCompared++; if (bus.session_open !== 1'b0) begin nMismatched++; $display("[TB] FAIL seq_session_closed: got %b expected 0", bus.session_open); end
  endtask

  task automatic test_bad_type();
    sendFrame(makeFrame(8'h09, 32'h0, 8'h40));
    nCompared++; if (cCode !== 8'h04) begin nMismatched++; $display("[TB] FAIL type_code: got %h expected 04", cCode); end
    nCompared++; if (cCause !== 2'd2) begin nMismatched++; $display("[TB] FAIL type_cause: got %0d expected 2", cCause); end
    sendFrame(makeFrame(T_FIRST, 32'd100, 8'h41));
    nCompared++; if (cCode !== 8'h05) begin nMismatched++; $display("[TB] FAIL open_code: got %h expected 05", cCode); end
    sendFrame(makeFrame(T_SINGLE, 32'd0, 8'h42));
    nCompared++; if (cCode !== (SEQ_ON ? 8'h04 : 8'h05)) begin nMismatched++; $display("[TB] FAIL single_in_session_code: got %h expected %h", cCode, (SEQ_ON ? 8'h04 : 8'h05)); end
    nCompared++; if (cCause !== (SEQ_ON ? 2'd3 : 2'd0)) begin nMismatched++; $display("[TB] FAIL single_in_session_cause: got %0d expected %0d", cCause, (SEQ_ON ? 2'd3 : 2'd0)); end
    sendFrame(makeFrame(T_LAST, 32'd101, 8'h43));
    nCompared++; if (cCode !== 8'h05) begin nMismatched++; $display("[TB] FAIL close_code: got %h expected 05", cCode); end
    nCompared++; if (cSess !== 1'b0) begin nMismatched++; $display("[TB] FAIL close_session: got %b expected 0", cSess); end
  endtask

  task automatic test_reset_mid_crc();
    int confirms;
    sendFrame(makeFrame(T_FIRST, 32'd1, 8'h50));
    nCompared++; if (cSess !== 1'b1) begin nMismatched++; $display("[TB] FAIL rstmid_session_before: got %b expected 1", cSess); end
    applyStimulus(makeFrame(T_SINGLE, 32'd0, 8'h51));
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    nCompared++; if (bus.busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL rstmid_busy: got %b expected 0", bus.busy); end
    nCompared++; if (bus.session_open !== 1'b0) begin nMismatched++; $display("[TB] FAIL rstmid_session: got %b expected 0", bus.session_open); end
    @(negedge clk);
    rst = 1'b0;
    confirms = 0;
    repeat (50) begin
      @(posedge clk);
      #1;
      if (bus.confirm) confirms++;
    end
    nCompared++; if (confirms !== 0) begin nMismatched++; $display("[TB] FAIL rstmid_no_confirm: got %0d confirms expected 0", confirms); end
    sendFrame(makeFrame(T_SINGLE, 32'd0, 8'h52));
    nCompared++; if (cEdges !== LATENCY) begin nMismatched++; $display("[TB] FAIL rstmid_next_latency: got %0d expected %0d", cEdges, LATENCY); end
    nCompared++; if (cCode !== 8'h05) begin nMismatched++; $display("[TB] FAIL rstmid_next_code: got %h expected 05", cCode); end
  endtask

  task automatic test_wrap();
    sendFrame(makeFrame(T_FIRST, 32'hFFFF_FFFF, 8'h60));
    nCompared++; if (cCode !== 8'h05) begin nMismatched++; $display("[TB] FAIL wrap_first_code: got %h expected 05", cCode); end
    sendFrame(makeFrame(T_NORMAL, 32'h0000_0000, 8'h61));
    nCompared++; if (cCode !== 8'h05) begin nMismatched++; $display("[TB] FAIL wrap_normal_code: got %h expected 05", cCode); end
    nCompared++; if (cType !== T_NORMAL) begin nMismatched++; $display("[TB] FAIL wrap_normal_type: got %h expected 02", cType); end
    sendFrame(makeFrame(T_LAST, 32'h0000_0001, 8'h62));
    nCompared++; if (cCode !== 8'h05) begin nMismatched++; $display("[TB] FAIL wrap_last_code: got %h expected 05", cCode); end
  endtask

  task automatic test_back_to_back();
    logic [0:FB-1] f1;
    logic [0:FB-1] f2;
    int confirms;
    f1 = makeFrame(T_SINGLE, 32'd0, 8'h70);
    f2 = makeFrame(T_SINGLE, 32'd0, 8'h90);
    applyStimulus(f1);
    confirms = 0;
    for (int e = 1; e <= 100; e++) begin
      @(posedge clk);
      #1;
      if (bus.confirm) begin
        confirms++;
        cPout = bus.pout;
      end
      if (e == 5) begin
        bus.fin       = f2;
        bus.fin_valid = 1'b1;
      end else begin
        bus.fin_valid = 1'b0;
      end
    end
    nCompared++; if (confirms !== 1) begin nMismatched++; $display("[TB] FAIL b2b_confirm_count: got %0d expected 1", confirms); end
    nCompared++; if (cPout !== f1[56 +: PB]) begin nMismatched++; $display("[TB] FAIL b2b_pout: got %h expected %h", cPout, f1[56 +: PB]); end
  endtask

  initial begin
    $display("[TB] frame_validator bench, sequence checking %0s", SEQ_ON ? "enabled" : "disabled");
    test_reset();
    test_single();
    test_crc_error();
    test_sequence();
    test_bad_type();
    test_reset_mid_crc();
    test_wrap();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
